// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the PC sequencer slice: FSM state encoding,
// trap/halt cause codes and the sequential fetch increment.
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  // Sequencer states; the numeric encoding is fixed so that a debugger
  // probing the state register sees stable values.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

  // Cause codes reported alongside the exception PC.
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_HALT     = 2'd2;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/instret_counter.sv
// ---------------------------------------------------------------------------
// instret_counter
// Free-running retired-instruction counter. It wraps to zero after its
// maximum value.
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous active-high reset, clears the count
//   i_inc    - increment enable (one retired instruction)
//   o_count  - current count
// ---------------------------------------------------------------------------
module instret_counter #(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_inc,
  output logic [INSTRET_W-1:0] o_count
);

  logic [INSTRET_W-1:0] r_count;

  // Reset takes priority, so no increment is ever recorded on a reset edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + INSTRET_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Computes the next PC for the program_counter register of the single-cycle
// core and sequences boot, sequential fetch, branch/jump redirects, stalls,
// misaligned-target traps and halt/resume. Also keeps the exception PC,
// the cause code and the retired-instruction count.
// Ports:
//   i_clk, i_reset                 - clock, synchronous active-high reset
//   i_pc_cur                       - current PC (PC register output)
//   i_stall                        - hold the current instruction
//   i_branch_taken/i_branch_target - taken conditional branch and target
//   i_jump/i_jump_target           - JAL/JALR and target
//   i_halt_req                     - ECALL/EBREAK decoded
//   i_resume                       - leave HALT
//   o_pc_next                      - next PC (PC register input)
//   o_fetch_valid                  - instruction at i_pc_cur may execute
//   o_retire                       - instruction at i_pc_cur completes
//   o_halted                       - sequencer is in HALT
//   o_epc, o_cause                 - last trapping/halting PC and its cause
//   o_instret                      - retired-instruction count
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          INSTRET_W    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_pc_cur,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic [31:0]          i_branch_target,
  input  logic                 i_jump,
  input  logic [31:0]          i_jump_target,
  input  logic                 i_halt_req,
  input  logic                 i_resume,
  output logic [31:0]          o_pc_next,
  output logic                 o_fetch_valid,
  output logic                 o_retire,
  output logic                 o_halted,
  output logic [31:0]          o_epc,
  output logic [1:0]           o_cause,
  output logic [INSTRET_W-1:0] o_instret
);

  seq_state_t  r_state;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;

  seq_state_t  w_stateNext;
  logic [31:0] w_pcNext;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_redirTarget;
  logic        w_fetchValid;
  logic        w_retire;
  logic        w_halted;
  logic        w_capture;
  logic [1:0]  w_causeNew;

  // Sequential successor wraps naturally modulo 2^32.
  assign w_pcPlus4 = i_pc_cur + PC_INCR;

  // Jump outranks a taken branch, so the redirect target follows i_jump.
  assign w_redirTarget = i_jump ? i_jump_target : i_branch_target;

  // Next-PC mux and transition logic. Reset overrides everything so that
  // a reset raised mid-trap or in HALT discards the pending transition and
  // suppresses retirement on that edge.
  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = i_pc_cur;
    w_fetchValid = 1'b0;
    w_retire     = 1'b0;
    w_halted     = 1'b0;
    w_capture    = 1'b0;
    w_causeNew   = CAUSE_NONE;

    if (i_reset) begin
      w_stateNext = ST_BOOT;
      w_pcNext    = RESET_VECTOR;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_pcNext    = RESET_VECTOR;
          w_stateNext = ST_RUN;
        end

        ST_RUN: begin
          w_fetchValid = 1'b1;
          if (i_stall) begin
            w_pcNext = i_pc_cur;
          end else if (i_halt_req) begin
            w_pcNext    = i_pc_cur;
            w_capture   = 1'b1;
            w_causeNew  = CAUSE_HALT;
            w_stateNext = ST_HALT;
          end else if (i_jump || i_branch_taken) begin
            // Targets must be word aligned; anything else traps in place.
            if (w_redirTarget[1:0] != 2'b00) begin
              w_pcNext    = i_pc_cur;
              w_capture   = 1'b1;
              w_causeNew  = CAUSE_MISALIGN;
              w_stateNext = ST_TRAP;
            end else begin
              w_pcNext = w_redirTarget;
              w_retire = 1'b1;
            end
          end else begin
            w_pcNext = w_pcPlus4;
            w_retire = 1'b1;
          end
        end

        ST_TRAP: begin
          w_pcNext    = TRAP_VECTOR;
          w_stateNext = ST_RUN;
        end

        ST_HALT: begin
          w_halted = 1'b1;
          // The halting instruction retires on the way out of HALT.
          if (i_resume) begin
            w_pcNext    = w_pcPlus4;
            w_retire    = 1'b1;
            w_stateNext = ST_RUN;
          end else begin
            w_pcNext = i_pc_cur;
          end
        end

        default: begin
          w_stateNext = ST_BOOT;
          w_pcNext    = RESET_VECTOR;
        end
      endcase
    end
  end

  // State register plus the exception PC and cause, which hold until the
  // next trap or halt overwrites them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_BOOT;
      r_epc   <= 32'h0000_0000;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_stateNext;
      if (w_capture) begin
        r_epc   <= i_pc_cur;
        r_cause <= w_causeNew;
      end
    end
  end

  instret_counter #(
    .INSTRET_W (INSTRET_W)
  ) u_instret (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_retire),
    .o_count (o_instret)
  );

  assign o_pc_next     = w_pcNext;
  assign o_fetch_valid = w_fetchValid;
  assign o_retire      = w_retire;
  assign o_halted      = w_halted;
  assign o_epc         = r_epc;
  assign o_cause       = r_cause;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block that computes the next-PC value for the `program_counter` register in the single-cycle RISC-V core and sequences its operation. It handles boot after reset, sequential fetch, branch and jump redirects, stall, misaligned-target traps, and halt/resume. It also maintains an exception PC and a retired-instruction counter. Its `pc_next` drives the PC register's `PC_in`, and the register's `PC_out` feeds back as `pc_cur`.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target on a misaligned-target trap.
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_cur`  in  32  current PC (`PC_out` of the PC register).
- `stall`  in  1  the current instruction must not complete; hold the PC.
- `branch_taken`  in  1  conditional branch resolved as taken.
- `branch_target`  in  32  branch target address.
- `jump`  in  1  JAL/JALR is executing.
- `jump_target`  in  32  jump target; bit 0 is already cleared for JALR.
- `halt_req`  in  1  ECALL/EBREAK decoded.
- `resume`  in  1  leave the HALT state.
- `pc_next`  out  32  next PC; connects to `PC_in`.
- `fetch_valid`  out  1  the instruction at `pc_cur` may execute and write state.
- `retire`  out  1  the instruction at `pc_cur` completes this cycle.
- `halted`  out  1  the block is in the HALT state.
- `epc`  out  32  PC of the last trapping or halting instruction.
- `cause`  out  2  cause code: 0 = none, 1 = misaligned target, 2 = halt request.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- FSM states: BOOT, RUN, TRAP, HALT.
- Reset:
  - While `reset` = 1, the state is forced to BOOT.
  - `epc` = 0, `cause` = 0, `instret` = 0.
  - `pc_next` = RESET_VECTOR.
  - `fetch_valid` = 0, `retire` = 0, `halted` = 0.
- BOOT (one cycle):
  - `pc_next` = RESET_VECTOR, `fetch_valid` = 0.
  - Transitions to RUN unconditionally.
- RUN: `fetch_valid` = 1. The first matching rule applies:
  1. `stall`: `pc_next` = `pc_cur`, no retire.
  2. `halt_req`: `pc_next` = `pc_cur`. Capture `epc` = `pc_cur` and `cause` = 2. Go to HALT. No retire.
  3. `jump`: if `jump_target[1:0]` ≠ 0, capture `epc` = `pc_cur` and `cause` = 1, set `pc_next` = `pc_cur`, go to TRAP, no retire. Otherwise `pc_next` = `jump_target`, retire.
  4. `branch_taken`: same handling as `jump`, using `branch_target`.
  5. Otherwise: `pc_next` = `pc_cur` + 4, retire.
- TRAP (one cycle):
  - `pc_next` = TRAP_VECTOR, `fetch_valid` = 0.
  - Transitions to RUN.
- HALT:
  - `pc_next` = `pc_cur`, `fetch_valid` = 0, `halted` = 1.
  - On `resume` = 1: `pc_next` = `pc_cur` + 4 and go to RUN. The halting instruction is retired on exit, so `retire` = 1 in that cycle.
- Arithmetic:
  - `pc_cur` + 4 is computed modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - `instret` increments on every `retire` and wraps to 0 at its maximum value.
- Inputs are ignored outside RUN, except `resume` in HALT.
- `epc` and `cause` hold their values until the next trap or halt; no other event clears them.

## Timing
- `pc_next`, `fetch_valid`, `retire` and `halted` are combinational from the state and inputs.
- `epc`, `cause`, `instret` and the FSM state are registered.
- A redirect takes effect in `pc_cur` one cycle after it is presented.
- Trap latency: the trapping cycle, then one TRAP cycle. `pc_cur` = TRAP_VECTOR two edges after the offending cycle.
- The first fetch is valid on the second rising edge after `reset` falls. The cycle after release is BOOT, and the BOOT-cycle edge loads RESET_VECTOR.
- `reset` asserted in any state, including mid-trap or in HALT, takes effect at the next edge. It discards the pending transition; no `retire` and no `instret` update occur on that edge.
- `halt_req` with `stall` in the same cycle: `stall` wins and the halt is re-evaluated the next cycle.
- `resume` arriving in the same cycle HALT is entered is ignored.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the state encoding (BOOT = 0, RUN = 1, TRAP = 2, HALT = 3);
  - the cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_HALT);
  - the constant PC_INCR = 4.
- One sub-module, `instret_counter`: a parameterized INSTRET_W-bit counter with `clk`, synchronous `reset`, and an increment enable driven by `retire`.
- The next-PC mux and the FSM stay in `pc_sequencer`.

## Test plan
- Boot: hold `reset` for 2 cycles, then release. Expect `pc_cur` sequence 0, 0, 4, 8. `fetch_valid` rises one cycle after release. `instret` = 2 after the 4 → 8 step.
- Branch and jump: at `pc_cur` = 0x8, `branch_taken` with target 0x40, then `jump` with target 0x80. Expect `pc_cur` = 0x40, then 0x80, with `retire` = 1 on both cycles.
- Misaligned target: at `pc_cur` = 0x10, `jump` with target 0x22. Expect `epc` = 0x10 and `cause` = 1. Next `pc_cur` = 0x10, then 0x100. `instret` unchanged.
- Stall priority: `stall` together with `branch_taken` for 3 cycles. Expect `pc_cur` constant, `retire` = 0, and the branch taken on the first non-stall cycle.
- Halt/resume: at `pc_cur` = 0x20, `halt_req`. Expect `halted` = 1, `epc` = 0x20, `cause` = 2, PC frozen for 5 cycles. `resume` gives `pc_cur` = 0x24 and `instret` + 1.
- Reset mid-trap, plus wrap: assert `reset` during TRAP and expect `pc_cur` to return to RESET_VECTOR. Separately, sequential fetch from 32'hFFFF_FFFC wraps to 0.
